// File: rtl/dma_calc_regs_axi4l.sv
// AXI4-Lite register block that configures and launches the DMA calc core and
// reports its completion through a sticky status bit and a registered level interrupt.
module dma_calc_regs_axi4l #(
    parameter int          AXI4L_ADDR_WIDTH = 40,
    parameter int          AXI4L_DATA_WIDTH = 64,
    parameter int          AXI4L_STRB_WIDTH = AXI4L_DATA_WIDTH / 8,
    parameter logic [63:0] CORE_ID          = 64'h0000_0000_0527_0001
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_awaddr,
    input  logic [2:0]                  s_axi4l_awprot,
    input  logic                        s_axi4l_awvalid,
    output logic                        s_axi4l_awready,
    input  logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_wdata,
    input  logic [AXI4L_STRB_WIDTH-1:0] s_axi4l_wstrb,
    input  logic                        s_axi4l_wvalid,
    output logic                        s_axi4l_wready,
    output logic [1:0]                  s_axi4l_bresp,
    output logic                        s_axi4l_bvalid,
    input  logic                        s_axi4l_bready,
    input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_araddr,
    input  logic [2:0]                  s_axi4l_arprot,
    input  logic                        s_axi4l_arvalid,
    output logic                        s_axi4l_arready,
    output logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_rdata,
    output logic [1:0]                  s_axi4l_rresp,
    output logic                        s_axi4l_rvalid,
    input  logic                        s_axi4l_rready,

    output logic                        core_start,
    output logic [63:0]                 core_src_addr,
    output logic [63:0]                 core_dst_addr,
    output logic [31:0]                 core_size,
    input  logic                        core_busy,
    input  logic                        core_done,
    output logic                        irq
);

    localparam logic [2:0] IDX_ID      = 3'd0;
    localparam logic [2:0] IDX_CONTROL = 3'd1;
    localparam logic [2:0] IDX_STATUS  = 3'd2;
    localparam logic [2:0] IDX_IRQ_EN  = 3'd3;
    localparam logic [2:0] IDX_IRQ_STS = 3'd4;
    localparam logic [2:0] IDX_SRC     = 3'd5;
    localparam logic [2:0] IDX_DST     = 3'd6;
    localparam logic [2:0] IDX_SIZE    = 3'd7;

    logic        r_bvalid;
    logic        r_rvalid;
    logic [63:0] r_rdata;
    logic        r_start;
    logic        r_done;
    logic        r_irq_en;
    logic        r_irq_sts;
    logic        r_irq;
    logic [63:0] r_src;
    logic [63:0] r_dst;
    logic [31:0] r_size;

    logic        w_wr_accept;
    logic        w_rd_accept;
    logic        w_start_req;
    logic        w_irq_clear;
    logic [2:0]  w_wr_idx;
    logic [2:0]  w_rd_idx;
    logic [63:0] w_rd_data;
    logic [63:0] w_src_next;
    logic [63:0] w_dst_next;
    logic [63:0] w_size_next;
    logic        w_unused;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  strb);
        merge_bytes = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) merge_bytes[8*i +: 8] = new_val[8*i +: 8];
        end
    endfunction

    // Readies are combinational so a transfer is accepted in the cycle it is offered;
    // reset masks them so nothing is taken until the first edge after release.
    assign w_wr_accept = s_axi4l_awvalid & s_axi4l_wvalid & ~r_bvalid & ~reset;
    assign w_rd_accept = s_axi4l_arvalid & ~r_rvalid & ~reset;
    assign w_wr_idx    = s_axi4l_awaddr[5:3];
    assign w_rd_idx    = s_axi4l_araddr[5:3];

    assign w_start_req = w_wr_accept & (w_wr_idx == IDX_CONTROL) & s_axi4l_wstrb[0] &
                         s_axi4l_wdata[0] & ~core_busy & ~r_start;
    assign w_irq_clear = w_wr_accept & (w_wr_idx == IDX_IRQ_STS) & s_axi4l_wstrb[0] &
                         s_axi4l_wdata[0];

    assign w_src_next  = merge_bytes(r_src, s_axi4l_wdata, s_axi4l_wstrb);
    assign w_dst_next  = merge_bytes(r_dst, s_axi4l_wdata, s_axi4l_wstrb);
    assign w_size_next = merge_bytes({32'd0, r_size}, s_axi4l_wdata, s_axi4l_wstrb);

    always_comb begin
        w_rd_data = 64'd0;
        case (w_rd_idx)
            IDX_ID:      w_rd_data = CORE_ID;
            IDX_CONTROL: w_rd_data = 64'd0;
            IDX_STATUS:  w_rd_data = {62'd0, r_done, core_busy};
            IDX_IRQ_EN:  w_rd_data = {63'd0, r_irq_en};
            IDX_IRQ_STS: w_rd_data = {63'd0, r_irq_sts};
            IDX_SRC:     w_rd_data = r_src;
            IDX_DST:     w_rd_data = r_dst;
            IDX_SIZE:    w_rd_data = {32'd0, r_size};
            default:     w_rd_data = 64'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 64'd0;
        end else begin
            if (w_wr_accept)         r_bvalid <= 1'b1;
            else if (s_axi4l_bready) r_bvalid <= 1'b0;
            if (w_rd_accept) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (s_axi4l_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // A completion wins over both the start-clear of done and a coincident W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_irq_en  <= 1'b0;
            r_irq_sts <= 1'b0;
            r_irq     <= 1'b0;
            r_src     <= 64'd0;
            r_dst     <= 64'd0;
            r_size    <= 32'd0;
        end else begin
            r_start <= w_start_req;
            r_irq   <= r_irq_en & r_irq_sts;
            if (core_done)    r_done <= 1'b1;
            else if (r_start) r_done <= 1'b0;
            if (core_done)        r_irq_sts <= 1'b1;
            else if (w_irq_clear) r_irq_sts <= 1'b0;
            if (w_wr_accept) begin
                case (w_wr_idx)
                    IDX_IRQ_EN: if (s_axi4l_wstrb[0]) r_irq_en <= s_axi4l_wdata[0];
                    IDX_SRC:    r_src  <= w_src_next;
                    IDX_DST:    r_dst  <= w_dst_next;
                    IDX_SIZE:   r_size <= w_size_next[31:0];
                    default:    ;
                endcase
            end
        end
    end

    assign s_axi4l_awready = w_wr_accept;
    assign s_axi4l_wready  = w_wr_accept;
    assign s_axi4l_arready = w_rd_accept;
    assign s_axi4l_bvalid  = r_bvalid;
    assign s_axi4l_bresp   = 2'b00;
    assign s_axi4l_rvalid  = r_rvalid;
    assign s_axi4l_rresp   = 2'b00;
    assign s_axi4l_rdata   = r_rdata;

    assign core_start    = r_start;
    assign core_src_addr = r_src;
    assign core_dst_addr = r_dst;
    assign core_size     = r_size;
    assign irq           = r_irq;

    assign w_unused = ^{s_axi4l_awprot, s_axi4l_arprot, s_axi4l_awaddr, s_axi4l_araddr,
                        w_size_next[63:32]};

endmodule

// File: doc/dma_calc_regs_axi4l.md
DMA_CALC_REGS_AXI4L -- requirements
Module: dma_calc_regs_axi4l

Interface
REQ-001 SHALL have parameter AXI4L_ADDR_WIDTH, default 40, AXI4-Lite address width.
REQ-002 SHALL have parameter AXI4L_DATA_WIDTH, default 64, AXI4-Lite data width (only 64 supported).
REQ-003 SHALL have parameter AXI4L_STRB_WIDTH, default AXI4L_DATA_WIDTH/8, byte-strobe width.
REQ-004 SHALL have parameter CORE_ID, default 64'h0000_0000_0527_0001, value of the ID register.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk (input, 1, sole clock, all logic rising-edge) and reset (input, 1, async active-high).
REQ-006 SHALL provide AXI4-Lite slave ports s_axi4l_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready (standard directions and widths; awprot/arprot 3 bits, ignored).
REQ-007 SHALL provide: core_start (output, 1, one-cycle start pulse), core_src_addr (output, 64), core_dst_addr (output, 64), core_size (output, 32, element count), core_busy (input, 1), core_done (input, 1, one-cycle completion pulse), irq (output, 1, level interrupt).

Function
REQ-008 SHALL decode register index from address bits [5:3]; bits [2:0] and bits above [5] ignored.
REQ-009 SHALL implement map: 0x00 CORE_ID RO; 0x08 CONTROL (bit0 start, W-only, reads 0); 0x10 STATUS RO (bit0 core_busy, bit1 done sticky); 0x18 IRQ_ENABLE RW bit0; 0x20 IRQ_STATUS bit0, write-1-to-clear; 0x28 SRC_ADDR RW 64; 0x30 DST_ADDR RW 64; 0x38 SIZE RW bits[31:0], upper bits read 0.
REQ-010 SHALL accept a write only when awvalid and wvalid are both high and bvalid is low, asserting awready and wready together for exactly that cycle.
REQ-011 SHALL update the register on the accept cycle edge, byte-wise per wstrb; bvalid SHALL rise the next cycle with bresp=2'b00 and hold until bready.
REQ-012 SHALL accept a read when arvalid is high and rvalid is low (arready high that cycle); rdata/rresp=2'b00/rvalid SHALL be registered one cycle later and held stable until rready.
REQ-013 SHALL sustain back-to-back transfers: with bready/rready held high, one write per 2 cycles and one read per 2 cycles.
REQ-014 SHALL allow read and write accepted in the same cycle to the same register; read returns the pre-write value.
REQ-015 SHALL treat unmapped indices as none (all eight mapped); writes with wstrb=0 SHALL complete with no register change.
REQ-016 SHALL pulse core_start for exactly one cycle, the cycle after a write of 1 to CONTROL bit0 with wstrb[0]=1, only if core_busy is low and no start pulse is in flight; otherwise the start SHALL be dropped silently.
REQ-017 SHALL set done sticky and IRQ_STATUS bit0 on core_done; done sticky SHALL clear on the start pulse.
REQ-018 SHALL give set priority when core_done coincides with a W1C write to IRQ_STATUS (bit stays 1).
REQ-019 SHALL drive irq = IRQ_ENABLE[0] & IRQ_STATUS[0], registered (one cycle after either changes).
REQ-020 SHALL drive core_src_addr/core_dst_addr/core_size directly from their registers; SW changes while busy SHALL take effect immediately (core must latch on start).

Reset
REQ-021 SHALL, on reset assertion, asynchronously clear: awready, wready, arready, bvalid, rvalid, core_start, irq to 0; rdata, bresp, rresp to 0; SRC_ADDR, DST_ADDR, SIZE, IRQ_ENABLE, IRQ_STATUS, done sticky to 0.
REQ-022 SHALL abandon any in-flight transaction on reset mid-operation; no bvalid/rvalid SHALL appear after deassertion without a new request.
REQ-023 SHALL accept a new transfer no earlier than the first clk edge after reset deassertion.

Verification
REQ-024 Read 0x00 after reset -> rvalid one cycle after arready, rdata=64'h0000_0000_0527_0001, rresp=0.
REQ-025 Write 0x28=64'h0000_0008_0000_1000 wstrb=8'h0F, then read 0x28 -> rdata=64'h0000_0000_0000_1000.
REQ-026 SIZE=128, write CONTROL=1 with core_busy=0 -> core_start high exactly 1 cycle; repeat with core_busy=1 -> no pulse.
REQ-027 IRQ_ENABLE=1, pulse core_done -> STATUS=2'b10 read, irq=1 next cycle; W1C IRQ_STATUS=1 -> irq=0; W1C coincident with core_done -> irq stays 1.
REQ-028 awvalid high, wvalid delayed 3 cycles, bready low 2 cycles -> awready/wready together on wvalid cycle, bvalid held 2 cycles, no duplicate write.
REQ-029 Assert reset while rvalid=1 and rready=0 -> rvalid drops immediately, all registers read back 0 (except CORE_ID) after release.
